// File: rtl/muldiv_sequencer.sv
// Sequences the shared multiply/divide units and the HI/LO write for the control unit.
// Optional watchdog abort in RUN is enabled by defining MULDIV_TIMEOUT_EN.
module muldiv_sequencer #(
    parameter int TIMEOUT = 48,
    parameter int CNT_W   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_mult,
    input  logic             req_div,
    input  logic             mult_stop,
    input  logic             div_stop,
    input  logic             div_zero,
    output logic             mult_start,
    output logic             div_start,
    output logic             hilo_select,
    output logic             hilo_write,
    output logic             busy,
    output logic             done,
    output logic             div_zero_exc,
    output logic             timeout_err,
    output logic [CNT_W-1:0] cycle_cnt
);

    if (TIMEOUT < 2 || (2 ** CNT_W) <= TIMEOUT) begin : g_param_check
        $error("muldiv_sequencer: need TIMEOUT >= 2 and 2**CNT_W > TIMEOUT");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        M_RUN = 3'd1,
        D_RUN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        EXC   = 3'd5
    } state_t;

    state_t            state_reg, state_next;
    logic              op_reg;
    logic              first_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  cycle_cnt_reg;
    logic              run;
    logic              tmo_hit;

    assign run = (state_reg == M_RUN) || (state_reg == D_RUN);

`ifdef MULDIV_TIMEOUT_EN
    logic exc_tmo_reg;
    assign tmo_hit = (cnt_reg == CNT_W'(TIMEOUT));
`else
    assign tmo_hit = 1'b0;
`endif

    // Flags from the units are ignored in the first RUN cycle; zero beats stop.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_mult)
                    state_next = M_RUN;
                else if (req_div)
                    state_next = D_RUN;
            end
            M_RUN: begin
                if (!first_reg && mult_stop)
                    state_next = WRITE;
                else if (tmo_hit)
                    state_next = EXC;
            end
            D_RUN: begin
                if (!first_reg && div_zero)
                    state_next = EXC;
                else if (!first_reg && div_stop)
                    state_next = WRITE;
                else if (tmo_hit)
                    state_next = EXC;
            end
            WRITE:   state_next = DONE;
            DONE:    state_next = IDLE;
            EXC:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            op_reg        <= 1'b0;
            first_reg     <= 1'b0;
            cnt_reg       <= '0;
            cycle_cnt_reg <= '0;
`ifdef MULDIV_TIMEOUT_EN
            exc_tmo_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && state_next != IDLE) begin
                op_reg    <= (state_next == D_RUN);
                first_reg <= 1'b1;
                cnt_reg   <= '0;
            end else if (run) begin
                first_reg <= 1'b0;
                if (cnt_reg != '1)
                    cnt_reg <= cnt_reg + 1'b1;
            end
            if (state_reg == WRITE || state_reg == EXC)
                cycle_cnt_reg <= cnt_reg;
`ifdef MULDIV_TIMEOUT_EN
            // Any EXC entry that is not a real divide-by-zero is a watchdog abort.
            if (run && state_next == EXC)
                exc_tmo_reg <= !(state_reg == D_RUN && !first_reg && div_zero);
`endif
        end
    end

    assign mult_start  = (state_reg == M_RUN) && first_reg;
    assign div_start   = (state_reg == D_RUN) && first_reg;
    assign hilo_select = op_reg;
    assign hilo_write  = (state_reg == WRITE);
    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == DONE);
    assign cycle_cnt   = cycle_cnt_reg;
`ifdef MULDIV_TIMEOUT_EN
    assign div_zero_exc = (state_reg == EXC) && !exc_tmo_reg;
    assign timeout_err  = (state_reg == EXC) && exc_tmo_reg;
`else
    assign div_zero_exc = (state_reg == EXC);
    assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected completions are queued at request
// time and popped when done / div_zero_exc / timeout_err pulses.
module tb_muldiv_sequencer;
    localparam int TIMEOUT = 10;
    localparam int CNT_W   = 6;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             req_mult = 1'b0, req_div = 1'b0;
    logic             mult_stop = 1'b0, div_stop = 1'b0, div_zero = 1'b0;
    logic             mult_start, div_start, hilo_select, hilo_write;
    logic             busy, done, div_zero_exc, timeout_err;
    logic [CNT_W-1:0] cycle_cnt;

    muldiv_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req_mult(req_mult), .req_div(req_div),
        .mult_stop(mult_stop), .div_stop(div_stop), .div_zero(div_zero),
        .mult_start(mult_start), .div_start(div_start),
        .hilo_select(hilo_select), .hilo_write(hilo_write),
        .busy(busy), .done(done), .div_zero_exc(div_zero_exc),
        .timeout_err(timeout_err), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok %s = %0d", tag, got);
        end
    endtask

    // kind is one-hot {done, div_zero_exc, timeout_err}
    typedef struct packed {
        logic [2:0]       kind;
        logic             sel;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             sb_q[$];
    logic             cnt_pend = 1'b0;
    logic [CNT_W-1:0] cnt_exp  = '0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (cnt_pend) begin
            check("cycle_cnt", 32'(cycle_cnt), 32'(cnt_exp));
            cnt_pend <= 1'b0;
        end
        if (reset && (done || div_zero_exc || timeout_err)) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_completion", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("completion_kind", 32'({done, div_zero_exc, timeout_err}), 32'(e.kind));
                check("completion_sel", 32'(hilo_select), 32'(e.sel));
                cnt_pend <= 1'b1;
                cnt_exp  <= e.cnt;
            end
        end
    end

    int ev_ms, ev_ds, ev_wr, ev_done, ev_exc, ev_idle;
    int n_ms, n_ds, n_wr, n_done, n_exc, n_tmo;
    logic wr_sel;

    // Cycle 0 carries the request; cycle c>0 outputs are sampled mid-cycle.
    task automatic run_op(input bit rm, input bit rd, input int stop_at, input bit zero,
                          input bit nag, input int max_c);
        ev_ms = -1; ev_ds = -1; ev_wr = -1; ev_done = -1; ev_exc = -1; ev_idle = -1;
        n_ms = 0; n_ds = 0; n_wr = 0; n_done = 0; n_exc = 0; n_tmo = 0; wr_sel = 1'bx;
        for (int c = 0; c <= max_c; c++) begin
            @(negedge clk);
            if (c > 0) begin
                if (mult_start) begin n_ms++; if (ev_ms < 0) ev_ms = c; end
                if (div_start) begin n_ds++; if (ev_ds < 0) ev_ds = c; end
                if (hilo_write) begin n_wr++; wr_sel = hilo_select; if (ev_wr < 0) ev_wr = c; end
                if (done) begin n_done++; if (ev_done < 0) ev_done = c; end
                if (div_zero_exc || timeout_err) begin n_exc++; if (ev_exc < 0) ev_exc = c; end
                if (timeout_err) n_tmo++;
            end
            req_mult  = (c == 0) && rm;
            req_div   = ((c == 0) && rd) || (nag && c == 3);
            mult_stop = (c == stop_at) && rm;
            div_stop  = (c == stop_at) && !rm;
            div_zero  = (c == stop_at) && zero;
            if (c > 0 && !busy) begin
                ev_idle = c;
                break;
            end
        end
        req_mult = 0; req_div = 0; mult_stop = 0; div_stop = 0; div_zero = 0;
        $display("[TB] op rm=%0d rd=%0d stop=%0d zero=%0d: ms@%0d ds@%0d wr@%0d done@%0d exc@%0d idle@%0d",
                 rm, rd, stop_at, zero, ev_ms, ev_ds, ev_wr, ev_done, ev_exc, ev_idle);
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({mult_start, div_start, hilo_select, hilo_write, busy, done,
                    div_zero_exc, timeout_err, cycle_cnt});
    endfunction

    initial begin
        // Reset held for 3 cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_outputs", all_outs(), 32'd0);
        end
        reset = 1'b1;

        // Long multiply: stop on cycle 33
        sb_q.push_back('{kind: 3'b100, sel: 1'b0, cnt: CNT_W'(33)});
        run_op(1'b1, 1'b0, 33, 1'b0, 1'b0, 60);
        check("mul_start_cycle", 32'(ev_ms), 32'd1);
        check("mul_start_count", 32'(n_ms), 32'd1);
        check("mul_write_cycle", 32'(ev_wr), 32'd34);
        check("mul_write_sel", 32'(wr_sel), 32'd0);
        check("mul_done_cycle", 32'(ev_done), 32'd35);
        check("mul_idle_cycle", 32'(ev_idle), 32'd36);
        check("mul_no_div_start", 32'(n_ds), 32'd0);

        // Divide-by-zero together with stop on the 5th RUN cycle
        sb_q.push_back('{kind: 3'b010, sel: 1'b1, cnt: CNT_W'(5)});
        run_op(1'b0, 1'b1, 5, 1'b1, 1'b0, 60);
        check("dz_start_cycle", 32'(ev_ds), 32'd1);
        check("dz_no_write", 32'(n_wr), 32'd0);
        check("dz_no_done", 32'(n_done), 32'd0);
        check("dz_exc_cycle", 32'(ev_exc), 32'd6);
        check("dz_idle_cycle", 32'(ev_idle), 32'd7);
        @(negedge clk);
        check("dz_select_held", 32'(hilo_select), 32'd1);

        // Both requests: multiply wins; repeated req_div while busy is dropped
        sb_q.push_back('{kind: 3'b100, sel: 1'b0, cnt: CNT_W'(2)});
        run_op(1'b1, 1'b1, 2, 1'b0, 1'b1, 20);
        check("both_mul_start", 32'(n_ms), 32'd1);
        check("both_no_div_start", 32'(n_ds), 32'd0);
        check("both_min_latency_done", 32'(ev_done), 32'd4);
        check("both_idle_cycle", 32'(ev_idle), 32'd5);
        @(negedge clk);
        check("nag_ignored_busy", 32'(busy), 32'd0);
        check("both_select_mult", 32'(hilo_select), 32'd0);

        // Asynchronous reset in the middle of D_RUN
        req_div = 1'b1;
        @(negedge clk);
        req_div = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_div_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1 check("async_reset_outputs", all_outs(), 32'd0);
        @(negedge clk);
        check("reset_hold_outputs", all_outs(), 32'd0);
        reset = 1'b1;

        sb_q.push_back('{kind: 3'b100, sel: 1'b1, cnt: CNT_W'(3)});
        run_op(1'b0, 1'b1, 3, 1'b0, 1'b0, 20);
        check("post_reset_div_done", 32'(ev_done), 32'd5);
        check("post_reset_div_write", 32'(n_wr), 32'd1);
        check("post_reset_div_sel", 32'(wr_sel), 32'd1);

`ifdef MULDIV_TIMEOUT_EN
        // Counter reads TIMEOUT in RUN cycle TIMEOUT+1, EXC follows
        sb_q.push_back('{kind: 3'b001, sel: 1'b1, cnt: CNT_W'(TIMEOUT + 1)});
        run_op(1'b0, 1'b1, -1, 1'b0, 1'b0, TIMEOUT + 10);
        check("tmo_pulses", 32'(n_tmo), 32'd1);
        check("tmo_exc_cycle", 32'(ev_exc), 32'(TIMEOUT + 2));
        check("tmo_no_write", 32'(n_wr), 32'd0);
        check("tmo_no_done", 32'(n_done), 32'd0);
`else
        run_op(1'b0, 1'b1, -1, 1'b0, 1'b0, TIMEOUT + 10);
        check("notmo_busy_held", 32'(busy), 32'd1);
        check("notmo_never_idle", 32'(ev_idle), 32'hffff_ffff);
        check("notmo_no_err", 32'(n_tmo), 32'd0);
        check("notmo_no_exc", 32'(n_exc), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
`endif
        @(negedge clk);
        @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
